// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, ALU operations
// and the per-instruction control bundle produced by the decoder.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    // Branches reuse SUB (equality) and SLT/SLTU (ordering); LUI passes the
    // immediate straight through.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e  alu_op;
        imm_fmt_e imm_fmt;
        logic     is_load;
        logic     is_store;
        logic     writes_rd;   // class writes rd (before the rd==0 check)
        logic     illegal;
        logic     uses_rs1;
        logic     uses_rs2;
    } ctrl_t;

    // Integer ALU op from funct3; sub_sel/sra_sel carry instr[30] where it matters.
    function automatic alu_op_e arith_op(input logic [2:0] funct3,
                                         input logic       sub_sel,
                                         input logic       sra_sel);
        case (funct3)
            3'd0:    return sub_sel ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return sra_sel ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Control decode from opcode, funct3 and instr[30]. Unknown opcodes are
    // flagged illegal, use no sources, write nothing and carry ALU_ADD.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       alt);
        ctrl_t c;
        c.alu_op    = ALU_ADD;
        c.imm_fmt   = IMM_NONE;
        c.is_load   = 1'b0;
        c.is_store  = 1'b0;
        c.writes_rd = 1'b0;
        c.illegal   = 1'b0;
        c.uses_rs1  = 1'b0;
        c.uses_rs2  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                c.imm_fmt   = IMM_U;
                c.alu_op    = ALU_PASS;
                c.writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                c.imm_fmt   = IMM_U;
                c.writes_rd = 1'b1;
            end
            OPC_JAL: begin
                c.imm_fmt   = IMM_J;
                c.writes_rd = 1'b1;
            end
            OPC_JALR: begin
                c.imm_fmt   = IMM_I;
                c.writes_rd = 1'b1;
                c.uses_rs1  = 1'b1;
            end
            OPC_BRANCH: begin
                c.imm_fmt  = IMM_B;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
                case (funct3[2:1])
                    2'b10:   c.alu_op = ALU_SLT;
                    2'b11:   c.alu_op = ALU_SLTU;
                    default: c.alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                c.imm_fmt   = IMM_I;
                c.is_load   = 1'b1;
                c.writes_rd = 1'b1;
                c.uses_rs1  = 1'b1;
            end
            OPC_STORE: begin
                c.imm_fmt  = IMM_S;
                c.is_store = 1'b1;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                c.imm_fmt   = IMM_I;
                c.alu_op    = arith_op(funct3, 1'b0, alt);
                c.writes_rd = 1'b1;
                c.uses_rs1  = 1'b1;
            end
            OPC_OP: begin
                c.alu_op    = arith_op(funct3, alt, alt);
                c.writes_rd = 1'b1;
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch -> decode valid/ready handshake carrying the instruction and its PC.
interface rv32_decode_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_valid;
    logic                  if_ready;
    logic [31:0]           if_instr;
    logic [DATA_WIDTH-1:0] if_pc;

    modport master (output if_valid, output if_instr, output if_pc, input if_ready);
    modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator: assembles the I/S/B/U/J immediate and
// sign-extends it (from instr[31]) to DATA_WIDTH.
module rv32_imm_gen
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  imm_fmt_e              fmt,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    // Bit scatter per immediate format; formats without an immediate give 0.
    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{21{instr[31]}}, instr[30:20]};
            IMM_S:   imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'(signed'(imm32));

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: addresses the register file straight from the incoming
// instruction, decodes control and immediate, and captures everything into a
// single ID/EX register behind a valid/ready handshake with load-use
// interlock and flush.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  NUM_REGISTERS = 32,
    localparam int AW            = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,          // asynchronous, active low
    rv32_decode_stage_if.slave    fetch,
    input  logic                  flush,
    output logic [AW-1:0]         reg_rd0,
    output logic [AW-1:0]         reg_rd1,
    input  logic [DATA_WIDTH-1:0] data_out0,
    input  logic [DATA_WIDTH-1:0] data_out1,
    output logic                  id_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_rs1_val,
    output logic [DATA_WIDTH-1:0] id_rs2_val,
    output logic [DATA_WIDTH-1:0] id_imm,
    output logic [AW-1:0]         id_rs1,
    output logic [AW-1:0]         id_rs2,
    output logic [AW-1:0]         id_rd,
    output alu_op_e               id_alu_op,
    output logic                  id_is_load,
    output logic                  id_is_store,
    output logic                  id_reg_write,
    output logic                  id_illegal
);

    logic [31:0]           instr;
    logic [AW-1:0]         rs1_f;
    logic [AW-1:0]         rs2_f;
    logic [AW-1:0]         rd_f;
    ctrl_t                 ctrl;
    logic [DATA_WIDTH-1:0] imm;
    logic                  hazard;
    logic                  ready_int;
    logic                  accept;
    logic                  reg_write_dec;

    assign instr = fetch.if_instr;
    assign rs1_f = AW'(instr[19:15]);
    assign rs2_f = AW'(instr[24:20]);
    assign rd_f  = AW'(instr[11:7]);

    // The register file is addressed directly from the fetch bus so its read
    // data arrives in the same cycle the instruction is accepted.
    assign reg_rd0 = rs1_f;
    assign reg_rd1 = rs2_f;

    assign ctrl = decode_ctrl(instr[6:0], instr[14:12], instr[30]);

    rv32_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (ctrl.imm_fmt),
        .imm   (imm)
    );

    // A load sitting in ID/EX cannot supply its result to the very next
    // instruction; hold that instruction back for one bubble so EX can
    // forward from MEM afterwards.
    assign hazard = id_valid && id_is_load && (id_rd != '0) &&
                    ((ctrl.uses_rs1 && (rs1_f == id_rd)) ||
                     (ctrl.uses_rs2 && (rs2_f == id_rd)));

    assign ready_int      = !flush && !hazard && (!id_valid || ex_ready);
    assign fetch.if_ready = ready_int;
    assign accept         = fetch.if_valid && ready_int;

    // x0 writes, stores, branches and illegal opcodes never write back.
    assign reg_write_dec = ctrl.writes_rd && (rd_f != '0);

    // ID/EX register: flush kills, accept loads, EX consumption leaves a
    // bubble, otherwise everything holds. Data fields are left stale on
    // flush/bubble since id_valid qualifies them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_alu_op    <= ALU_ADD;
            id_is_load   <= 1'b0;
            id_is_store  <= 1'b0;
            id_reg_write <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid     <= 1'b1;
            id_pc        <= fetch.if_pc;
            id_rs1_val   <= data_out0;
            id_rs2_val   <= data_out1;
            id_imm       <= imm;
            id_rs1       <= rs1_f;
            id_rs2       <= rs2_f;
            id_rd        <= rd_f;
            id_alu_op    <= ctrl.alu_op;
            id_is_load   <= ctrl.is_load;
            id_is_store  <= ctrl.is_store;
            id_reg_write <= reg_write_dec;
            id_illegal   <= ctrl.illegal;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed + randomized bench for rv32_decode_stage with a transaction-level
// reference model of the ID/EX register.
module tb_rv32_decode_stage;
    import rv32_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32_decode_stage_if #(.DATA_WIDTH(DW)) fetch_if ();

    logic          flush;
    logic          ex_ready;
    logic [AW-1:0] reg_rd0, reg_rd1;
    logic [DW-1:0] data_out0, data_out1;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    alu_op_e       id_alu_op;
    logic          id_is_load, id_is_store, id_reg_write, id_illegal;

    rv32_decode_stage #(.DATA_WIDTH(DW), .NUM_REGISTERS(32)) dut (
        .clk(clk), .rst(rst), .fetch(fetch_if), .flush(flush),
        .reg_rd0(reg_rd0), .reg_rd1(reg_rd1),
        .data_out0(data_out0), .data_out1(data_out1),
        .id_valid(id_valid), .ex_ready(ex_ready),
        .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .id_reg_write(id_reg_write), .id_illegal(id_illegal)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc, rs1_val, rs2_val, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        is_load, is_store, reg_write, illegal;
    } rec_t;

    logic m_valid;
    rec_t m_rec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Immediate from the RV32I encoding tables, built with masks and shifts.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] sx;
        sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return (sx << 11) | ((w >> 20) & 32'h7FF);
            7'h23: return (sx << 11) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1F);
            7'h63: return (sx << 12) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0)
                          | ((w >> 7) & 32'h1E);
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F: return (sx << 20) | (w & 32'h000F_F000) | ((w >> 9) & 32'h800)
                          | ((w >> 20) & 32'h7FE);
            default: return 32'h0;
        endcase
    endfunction

    function automatic alu_op_e ref_f3_op(input logic [2:0] f3);
        case (f3)
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd6: return ALU_OR;
            3'd7: return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic rec_t ref_dec(input logic [31:0] w, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        rec_t r;
        logic writes;
        logic [2:0] f3;
        f3 = w[14:12];
        r.pc = pc; r.rs1_val = a; r.rs2_val = b;
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
        r.imm = ref_imm(w);
        r.alu_op = ALU_ADD;
        r.is_load = (w[6:0] == 7'h03);
        r.is_store = (w[6:0] == 7'h23);
        r.illegal = 1'b0;
        writes = 1'b0;
        case (w[6:0])
            7'h37: begin r.alu_op = ALU_PASS; writes = 1'b1; end
            7'h17, 7'h6F, 7'h67, 7'h03: writes = 1'b1;
            7'h23: ;
            7'h63: r.alu_op = (f3 >= 3'd6) ? ALU_SLTU : (f3 >= 3'd4) ? ALU_SLT : ALU_SUB;
            7'h13: begin
                writes = 1'b1;
                r.alu_op = (f3 == 3'd5) ? (w[30] ? ALU_SRA : ALU_SRL) : ref_f3_op(f3);
            end
            7'h33: begin
                writes = 1'b1;
                if (f3 == 3'd0)      r.alu_op = w[30] ? ALU_SUB : ALU_ADD;
                else if (f3 == 3'd5) r.alu_op = w[30] ? ALU_SRA : ALU_SRL;
                else                 r.alu_op = ref_f3_op(f3);
            end
            default: r.illegal = 1'b1;
        endcase
        r.reg_write = writes && (r.rd != 5'd0);
        return r;
    endfunction

    // Which source registers a format reads: R/S/B both, I/LOAD/JALR rs1.
    function automatic logic [1:0] ref_uses(input logic [6:0] opc);
        case (opc)
            7'h33, 7'h23, 7'h63: return 2'b11;
            7'h13, 7'h03, 7'h67: return 2'b01;
            default:             return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic exr, input logic fl);
        fetch_if.if_valid = v; fetch_if.if_instr = ins; fetch_if.if_pc = pc;
        data_out0 = d0; data_out1 = d1; ex_ready = exr; flush = fl;
    endtask

    task automatic check_id();
        chk("id_valid", id_valid, m_valid);
        if (m_valid) begin
            chk("id_pc", id_pc, m_rec.pc);
            chk("id_rs1_val", id_rs1_val, m_rec.rs1_val);
            chk("id_rs2_val", id_rs2_val, m_rec.rs2_val);
            chk("id_imm", id_imm, m_rec.imm);
            chk("id_rs1", id_rs1, m_rec.rs1);
            chk("id_rs2", id_rs2, m_rec.rs2);
            chk("id_rd", id_rd, m_rec.rd);
            chk("id_alu_op", id_alu_op, m_rec.alu_op);
            chk("id_is_load", id_is_load, m_rec.is_load);
            chk("id_is_store", id_is_store, m_rec.is_store);
            chk("id_reg_write", id_reg_write, m_rec.reg_write);
            chk("id_illegal", id_illegal, m_rec.illegal);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_rs1_val", id_rs1_val, 0);
        chk("rst_rs2_val", id_rs2_val, 0);
        chk("rst_imm", id_imm, 0);
        chk("rst_regs", {id_rs1, id_rs2, id_rd}, 0);
        chk("rst_ctrl", {id_alu_op, id_is_load, id_is_store, id_reg_write, id_illegal}, 0);
    endtask

    // One clock: check combinational outputs, step the model, check ID/EX.
    task automatic cycle();
        logic [1:0]  uses;
        logic [31:0] w;
        logic        hz, exp_rdy, n_valid;
        rec_t        n_rec;
        #1;
        w = fetch_if.if_instr;
        uses = ref_uses(w[6:0]);
        hz = m_valid && m_rec.is_load && (m_rec.rd != 5'd0) &&
             ((uses[0] && w[19:15] == m_rec.rd) || (uses[1] && w[24:20] == m_rec.rd));
        exp_rdy = !flush && !hz && (!m_valid || ex_ready);
        chk("if_ready", fetch_if.if_ready, exp_rdy);
        chk("reg_rd0", reg_rd0, w[19:15]);
        chk("reg_rd1", reg_rd1, w[24:20]);
        n_valid = m_valid;
        n_rec = m_rec;
        if (flush) n_valid = 1'b0;
        else if (fetch_if.if_valid && exp_rdy) begin
            n_valid = 1'b1;
            n_rec = ref_dec(w, fetch_if.if_pc, data_out0, data_out1);
            $display("[TB] accept pc=%08h instr=%08h", fetch_if.if_pc, w);
        end else if (ex_ready) n_valid = 1'b0;
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_rec = n_rec;
        check_id();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_state();
        end
        rst = 1'b1;
        flush = 1'b0;
        #1 chk("ready_after_reset", fetch_if.if_ready, 1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10];
        logic [31:0] w;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) < 7) begin
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
        end
        return w;
    endfunction

    initial begin
        m_valid = 1'b0;
        m_rec = ref_dec(32'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        do_reset();

        // ADDI x5,x1,-1 with rs1 data 0x10
        drive(1, 32'hFFF08293, 32'h100, 32'h10, 32'h0, 1, 0);
        cycle();
        chk("addi_valid", id_valid, 1);
        chk("addi_rd", id_rd, 5);
        chk("addi_imm", id_imm, 32'hFFFF_FFFF);
        chk("addi_rs1_val", id_rs1_val, 32'h10);
        chk("addi_wr", id_reg_write, 1);

        // EX backpressure for two cycles, then release
        drive(1, 32'h00208333, 32'h104, 32'h7, 32'h9, 0, 0);
        repeat (2) begin
            cycle();
            chk("stall_ready", fetch_if.if_ready, 0);
            chk("stall_pc_hold", id_pc, 32'h100);
        end
        ex_ready = 1'b1;
        cycle();
        chk("release_pc", id_pc, 32'h104);
        chk("release_rd", id_rd, 6);

        // load-use: LW x3,0(x2) then ADD x4,x3,x1
        drive(1, 32'h00012183, 32'h108, 32'h40, 32'h0, 1, 0);
        cycle();
        chk("lw_is_load", id_is_load, 1);
        drive(1, 32'h00118233, 32'h10C, 32'h5, 32'h6, 1, 0);
        #1 chk("lu_ready", fetch_if.if_ready, 0);
        cycle();
        chk("lu_bubble", id_valid, 0);
        cycle();
        chk("lu_add_valid", id_valid, 1);
        chk("lu_add_pc", id_pc, 32'h10C);

        // flush with a live instruction and a valid incoming one
        drive(1, 32'h00308393, 32'h110, 32'h1, 32'h2, 0, 1);
        cycle();
        chk("flush_kill", id_valid, 0);
        drive(0, 32'h00308393, 32'h110, 32'h1, 32'h2, 1, 0);
        cycle();
        chk("flush_noaccept", id_valid, 0);

        // ADD x0 never writes; unknown opcode flows through as illegal
        drive(1, 32'h00208033, 32'h114, 32'h3, 32'h4, 1, 0);
        cycle();
        chk("x0_wr", id_reg_write, 0);
        drive(1, 32'h0000007F, 32'h118, 32'h3, 32'h4, 1, 0);
        cycle();
        chk("ill_flag", id_illegal, 1);
        chk("ill_wr", id_reg_write, 0);
        chk("ill_alu", id_alu_op, ALU_ADD);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
